release_sequencer: RTL

//  In-order release controller for NUM_LANES store_and_release lanes. Owns the global

---
 rtl/phj_pkg.sv | 5 +
 rtl/release_sequencer_if.sv | 22 ++
 rtl/lowest_onehot.sv | 9 +
 rtl/release_sequencer.sv | 72 +++++++
 4 files changed

// File: rtl/phj_pkg.sv
// phj_pkg: shared state encoding and serial width for the release sequencer
package phj_pkg;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_DRAIN, SEQ_DONE} seq_state_t;
  localparam int SERIAL_W = 32;
endpackage

// File: rtl/release_sequencer_if.sv
// release_sequencer_if: control, lane and status signals between sequencer and its environment
interface release_sequencer_if #(parameter int NUM_LANES = 4);
  logic                         start;
  logic                         total_valid;
  logic [phj_pkg::SERIAL_W-1:0] total_count;
  logic [NUM_LANES-1:0]         lane_next_in_storage;
  logic [NUM_LANES-1:0]         lane_last_processed;
  logic [NUM_LANES-1:0]         lane_release_data;
  logic [phj_pkg::SERIAL_W-1:0] next;
  logic                         busy;
  logic                         done;
  logic                         conflict_err;
  logic                         stall_timeout;
  modport master (
    output start, total_valid, total_count, lane_next_in_storage, lane_last_processed,
    input  lane_release_data, next, busy, done, conflict_err, stall_timeout
  );
  modport slave (
    input  start, total_valid, total_count, lane_next_in_storage, lane_last_processed,
    output lane_release_data, next, busy, done, conflict_err, stall_timeout
  );
endinterface

// File: rtl/lowest_onehot.sv
// lowest_onehot: isolates the lowest set bit of vec and flags more than one set bit
module lowest_onehot #(parameter int W = 4) (
  input  logic [W-1:0] vec,
  output logic [W-1:0] grant,
  output logic         multi
);
  assign grant = vec & (~vec + W'(1));
  assign multi = (vec & (vec - W'(1))) != '0;
endmodule

// File: rtl/release_sequencer.sv
// release_sequencer: in-order serial release across lanes with end-of-stream drain and fault flags
module release_sequencer
  import phj_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int STALL_LIMIT = 1024
) (
  input logic               clk,
  input logic               resetn,
  release_sequencer_if.slave bus
);
  localparam int CW = $clog2(STALL_LIMIT + 1);
  seq_state_t            state_q;
  logic [SERIAL_W-1:0]   next_q;
  logic [CW-1:0]         stall_q;
  logic                  busy_q, done_q, conf_q, to_q;
  logic [NUM_LANES-1:0]  grant;
  logic                  multi, end_c, grant_v;
  lowest_onehot #(.W(NUM_LANES)) u_lowest (
    .vec   (bus.lane_next_in_storage),
    .grant (grant),
    .multi (multi)
  );
  assign end_c   = bus.total_valid && next_q == bus.total_count;
  assign grant_v = state_q == SEQ_RUN && !end_c && |bus.lane_next_in_storage;
  assign bus.lane_release_data = grant_v ? grant : '0;
  assign bus.next          = next_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.conflict_err  = conf_q;
  assign bus.stall_timeout = to_q;
  // sequencing FSM: serial counter, stall watchdog, sticky fault flags and status outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= SEQ_IDLE;
      next_q  <= '0;
      stall_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      conf_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      case (state_q)
        SEQ_IDLE, SEQ_DONE: if (bus.start) begin
          state_q <= SEQ_RUN;
          next_q  <= '0;
          stall_q <= '0;
          conf_q  <= 1'b0;
          to_q    <= 1'b0;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
        end
        SEQ_RUN: if (end_c) begin
          state_q <= SEQ_DRAIN;
        end else if (grant_v) begin
          next_q  <= next_q + SERIAL_W'(1);
          stall_q <= '0;
          if (multi) conf_q <= 1'b1;
        end else begin
          if (stall_q < CW'(STALL_LIMIT)) stall_q <= stall_q + CW'(1);
          if (stall_q >= CW'(STALL_LIMIT - 1)) to_q <= 1'b1;
        end
        SEQ_DRAIN: if (&bus.lane_last_processed) begin
          state_q <= SEQ_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= SEQ_IDLE;
      endcase
    end
  end
endmodule
